// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared bus widths, DMA addresses and FSM state encoding
package nes_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [ADDR_W-1:0] OAM_DATA_ADDR_DEF = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_e;

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// rtl/oam_dma_arbiter_if.sv - single-port RAM bus: master drives address/strobe, slave returns read data
interface oam_dma_arbiter_if;
    import nes_bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw_n;
    logic              cs_n;
    logic [DATA_W-1:0] rdata;

    modport master (
        output addr,
        output wdata,
        output rw_n,
        output cs_n,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  rw_n,
        input  cs_n,
        output rdata
    );

endinterface

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - shares the RAM bus between CPU and a 256-byte OAM DMA page copy
// Optional one-cycle parity alignment before the first read: OAM_DMA_ALIGN_EN.
module oam_dma_arbiter
    import nes_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    oam_dma_arbiter_if.slave  cpu_bus,
    oam_dma_arbiter_if.master mem_bus,
    output logic              cpu_rdy,
    output logic              dma_busy
);

    dma_state_e        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [DATA_W-1:0] page_q, page_d;
    logic              trigger;

    assign trigger = (cpu_bus.cs_n == 1'b0) && (cpu_bus.rw_n == 1'b0)
                  && (cpu_bus.addr == DMA_REG_ADDR);

    // Read data is never intercepted; the CPU simply ignores it while halted.
    assign cpu_bus.rdata = mem_bus.rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'h00;
            page_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        page_d        = page_q;
        mem_bus.addr  = cpu_bus.addr;
        mem_bus.wdata = cpu_bus.wdata;
        mem_bus.rw_n  = cpu_bus.rw_n;
        mem_bus.cs_n  = cpu_bus.cs_n;
        cpu_rdy       = 1'b0;
        dma_busy      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
                if (trigger) begin
                    page_d  = cpu_bus.wdata;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                mem_bus.addr  = {page_q, idx_q};
                mem_bus.wdata = '0;
                mem_bus.rw_n  = 1'b1;
                mem_bus.cs_n  = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? ST_ALIGN : ST_READ;
`else
                state_d = ST_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ST_ALIGN: begin
                mem_bus.addr  = {page_q, idx_q};
                mem_bus.wdata = '0;
                mem_bus.rw_n  = 1'b1;
                mem_bus.cs_n  = 1'b1;
                state_d       = ST_READ;
            end
`endif
            ST_READ: begin
                mem_bus.addr  = {page_q, idx_q};
                mem_bus.wdata = '0;
                mem_bus.rw_n  = 1'b1;
                mem_bus.cs_n  = 1'b0;
                state_d       = ST_WRITE;
            end
            ST_WRITE: begin
                // RAM data from the READ cycle arrives now and goes straight out.
                mem_bus.addr  = OAM_DATA_ADDR;
                mem_bus.wdata = mem_bus.rdata;
                mem_bus.rw_n  = 1'b0;
                mem_bus.cs_n  = 1'b0;
                idx_d         = idx_q + 8'd1;
                state_d       = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - randomized self-checking bench for oam_dma_arbiter
module tb_oam_dma_arbiter;
    import nes_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rdy, dma_busy;

    oam_dma_arbiter_if cpu_bus();
    oam_dma_arbiter_if mem_bus();

    oam_dma_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_bus  (cpu_bus),
        .mem_bus  (mem_bus),
        .cpu_rdy  (cpu_rdy),
        .dma_busy (dma_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ram [0:65535];
    int unsigned edges;

    // Edges since reset release; its low bit is the expected parity.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(posedge clk) begin
        if (mem_bus.cs_n == 1'b0 && mem_bus.rw_n == 1'b1)
            mem_bus.rdata <= ram[mem_bus.addr];
    end

    task automatic cpu_idle();
        cpu_bus.addr  = 16'h0000;
        cpu_bus.wdata = 8'h00;
        cpu_bus.rw_n  = 1'b1;
        cpu_bus.cs_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_idle();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cpu_rdy, dma_busy, mem_bus.cs_n} !== 3'b101) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy/busy/cs_n=%b want 101", {cpu_rdy, dma_busy, mem_bus.cs_n});
        end
        rst_n = 1'b1;
        @(negedge clk);
        cpu_bus.addr = 16'h0010; cpu_bus.rw_n = 1'b1; cpu_bus.cs_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_bus.addr, mem_bus.rw_n, mem_bus.cs_n, cpu_rdy, dma_busy} !== {16'h0010, 4'b1010}) begin
            n_err++;
            $display("FAIL first_read: got addr=%h rw_n=%b cs_n=%b rdy=%b busy=%b want 0010 1 0 1 0",
                     mem_bus.addr, mem_bus.rw_n, mem_bus.cs_n, cpu_rdy, dma_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_bus.rdata !== ram[16'h0010]) begin
            n_err++;
            $display("FAIL first_read_data: got %h want %h", cpu_bus.rdata, ram[16'h0010]);
        end
        cpu_idle();
    endtask

    task automatic test_passthrough();
        logic [15:0] a, prev_a;
        logic [7:0]  d;
        logic        rw, cs, prev_rd;
        prev_rd = 1'b0;
        prev_a  = 16'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (prev_rd) begin
                n_cmp++;
                if (cpu_bus.rdata !== ram[prev_a]) begin
                    n_err++;
                    $display("FAIL pass_rdata: addr %h got %h want %h", prev_a, cpu_bus.rdata, ram[prev_a]);
                end
            end
            a  = 16'($urandom);
            d  = 8'($urandom);
            rw = 1'($urandom);
            cs = ($urandom_range(0, 3) == 0);
            if (a == DMA_REG_ADDR_DEF) rw = 1'b1;
            cpu_bus.addr = a; cpu_bus.wdata = d; cpu_bus.rw_n = rw; cpu_bus.cs_n = cs;
            #1;
            n_cmp++;
            if ({mem_bus.addr, mem_bus.wdata, mem_bus.rw_n, mem_bus.cs_n, cpu_rdy} !== {a, d, rw, cs, 1'b1}) begin
                n_err++;
                $display("FAIL pass_mirror: got %h/%h/%b/%b rdy=%b want %h/%h/%b/%b rdy=1",
                         mem_bus.addr, mem_bus.wdata, mem_bus.rw_n, mem_bus.cs_n, cpu_rdy, a, d, rw, cs);
            end
            prev_rd = (cs == 1'b0) && rw;
            prev_a  = a;
        end
        cpu_idle();
    endtask

    // want_par < 0: trigger now; b2b: caller is already at the first IDLE negedge.
    task automatic run_dma(input logic [7:0] page, input int want_par, input bit b2b, input int abort_at);
        logic [15:0] rd_q[$];
        logic [7:0]  wr_q[$];
        int halt, other, busy_bad, exp_halt, rd_bad, wr_bad, late_wr, late_halt;
        bit par;
        halt = 0; other = 0; busy_bad = 0; rd_bad = 0; wr_bad = 0;
        if (!b2b) @(negedge clk);
        if (want_par >= 0) begin
            while (((edges + 1) % 2) != want_par) begin
                cpu_idle();
                @(negedge clk);
            end
        end
        par = ((edges + 1) % 2) == 1;
`ifdef OAM_DMA_ALIGN_EN
        exp_halt = par ? 514 : 513;
`else
        exp_halt = 513;
`endif
        cpu_bus.addr = DMA_REG_ADDR_DEF; cpu_bus.wdata = page; cpu_bus.rw_n = 1'b0; cpu_bus.cs_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_bus.addr, mem_bus.wdata, mem_bus.rw_n, mem_bus.cs_n, cpu_rdy} !== {DMA_REG_ADDR_DEF, page, 3'b001}) begin
            n_err++;
            $display("FAIL trigger_pass: got %h/%h/%b/%b rdy=%b want %h/%h/0/0 rdy=1",
                     mem_bus.addr, mem_bus.wdata, mem_bus.rw_n, mem_bus.cs_n, cpu_rdy, DMA_REG_ADDR_DEF, page);
        end
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (cpu_rdy === 1'b1) break;
            halt++;
            if (dma_busy !== 1'b1) busy_bad++;
            if (mem_bus.cs_n === 1'b0) begin
                if (mem_bus.rw_n) rd_q.push_back(mem_bus.addr);
                else if (mem_bus.addr == OAM_DATA_ADDR_DEF) wr_q.push_back(mem_bus.wdata);
                else other++;
            end
            if (abort_at > 0 && wr_q.size() == abort_at) begin
                rst_n = 1'b0;
                cpu_idle();
                #1;
                n_cmp++;
                if ({cpu_rdy, dma_busy, mem_bus.cs_n} !== 3'b101) begin
                    n_err++;
                    $display("FAIL abort_now: got rdy/busy/cs_n=%b want 101", {cpu_rdy, dma_busy, mem_bus.cs_n});
                end
                n_cmp++;
                if (rd_q.size() !== abort_at) begin
                    n_err++;
                    $display("FAIL abort_reads: got %0d want %0d", rd_q.size(), abort_at);
                end
                @(negedge clk);
                rst_n = 1'b1;
                late_wr = 0; late_halt = 0;
                for (int k = 0; k < 600; k++) begin
                    @(negedge clk);
                    if (mem_bus.cs_n === 1'b0 && mem_bus.rw_n === 1'b0 && mem_bus.addr == OAM_DATA_ADDR_DEF) late_wr++;
                    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) late_halt++;
                end
                n_cmp++;
                if (late_wr !== 0 || late_halt !== 0) begin
                    n_err++;
                    $display("FAIL abort_after: got %0d oam writes, %0d halted cycles want 0 0", late_wr, late_halt);
                end
                return;
            end
            if (halt < 400 && $urandom_range(0, 3) == 0) begin
                cpu_bus.addr = DMA_REG_ADDR_DEF; cpu_bus.wdata = 8'($urandom); cpu_bus.rw_n = 1'b0; cpu_bus.cs_n = 1'b0;
            end else begin
                cpu_bus.addr = 16'h0300 + 16'($urandom_range(0, 255));
                cpu_bus.wdata = 8'($urandom); cpu_bus.rw_n = 1'($urandom); cpu_bus.cs_n = 1'($urandom);
            end
        end
        cpu_idle();
        n_cmp++;
        if (halt !== exp_halt) begin
            n_err++;
            $display("FAIL halt_len: page %h parity %0d got %0d cycles want %0d", page, par, halt, exp_halt);
        end
        n_cmp++;
        if (rd_q.size() !== 256 || wr_q.size() !== 256 || other !== 0 || busy_bad !== 0) begin
            n_err++;
            $display("FAIL dma_counts: got reads=%0d writes=%0d other=%0d busy_low=%0d want 256 256 0 0",
                     rd_q.size(), wr_q.size(), other, busy_bad);
        end
        for (int i = 0; i < 256 && i < rd_q.size(); i++)
            if (rd_q[i] !== {page, 8'(i)}) rd_bad++;
        for (int i = 0; i < 256 && i < wr_q.size(); i++)
            if (wr_q[i] !== ram[{page, 8'(i)}]) wr_bad++;
        n_cmp++;
        if (rd_bad !== 0 || (rd_q.size() > 0 && rd_q[0] !== {page, 8'h00})) begin
            n_err++;
            $display("FAIL read_addrs: page %h got %0d bad, first %h want first %h", page, rd_bad,
                     (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx, {page, 8'h00});
        end
        n_cmp++;
        if (wr_bad !== 0) begin
            n_err++;
            $display("FAIL oam_data: page %h got %0d wrong bytes want 0", page, wr_bad);
        end
        n_cmp++;
        if (dma_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_end: got %b want 0", dma_busy);
        end
        if (page == 8'hFF) begin
            n_cmp++;
            if (rd_q.size() == 0 || rd_q[rd_q.size()-1] !== 16'hFFFF || (16'h0000 inside {rd_q})) begin
                n_err++;
                $display("FAIL page_ff_wrap: got last %h want FFFF and no 0000",
                         (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 16'hxxxx);
            end
        end
    endtask

    task automatic test_dma_parity0();
        run_dma(8'h02, 0, 1'b0, 0);
    endtask

    task automatic test_dma_parity1();
        run_dma(8'h02, 1, 1'b0, 0);
    endtask

    task automatic test_page_ff_back_to_back();
        run_dma(8'hFF, -1, 1'b0, 0);
        run_dma(8'($urandom_range(0, 254)), -1, 1'b1, 0);
    endtask

    task automatic test_random_pages();
        for (int i = 0; i < 2; i++)
            run_dma(8'($urandom), -1, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        run_dma(8'($urandom), -1, 1'b0, 100);
    endtask

    task automatic test_no_trigger();
        int bad;
        bad = 0;
        @(negedge clk);
        cpu_bus.addr = DMA_REG_ADDR_DEF; cpu_bus.wdata = 8'h05; cpu_bus.rw_n = 1'b1; cpu_bus.cs_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) bad++;
        end
        cpu_bus.rw_n = 1'b0; cpu_bus.cs_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || mem_bus.cs_n !== 1'b1) bad++;
        end
        cpu_idle();
        repeat (10) begin
            @(negedge clk);
            if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL no_trigger: got %0d halted/busy cycles want 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        cpu_idle();
        test_reset();
        test_passthrough();
        test_dma_parity0();
        test_dma_parity1();
        test_page_ff_back_to_back();
        test_random_pages();
        test_reset_mid();
        test_no_trigger();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
